// File: rtl/sipo_packer_pkg.sv
// sipo_pkg: shared defaults and sizing helpers for the serial-in/parallel-out packer.
package sipo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int LAST_BIT = DEF_WIDTH - 1;
  typedef logic [$clog2(DEF_WIDTH)-1:0] cnt_t;
  function automatic int last_idx(input int w);
    return w - 1;
  endfunction
endpackage

// File: rtl/sipo_packer_if.sv
// sipo_i: bit-stream input and word valid/ready output of the packer, with clock and reset.
interface sipo_i #(parameter int WIDTH = sipo_pkg::DEF_WIDTH) (input logic clk, input logic rst);
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic [WIDTH-1:0] word_out;
  logic word_valid;
  logic word_ready;
  modport dut (input clk, rst, bit_in, bit_valid, word_ready, output bit_ready, word_out, word_valid);
  modport tb (input clk, rst, bit_ready, word_out, word_valid, output bit_in, bit_valid, word_ready);
endinterface

// File: rtl/sipo_packer_out_reg.sv
// sipo_out_reg: one-word holding register presenting packed words on a valid/ready port.
module sipo_out_reg #(parameter int WIDTH = sipo_pkg::DEF_WIDTH) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [WIDTH-1:0] din,
  input  logic word_ready,
  output logic word_valid,
  output logic [WIDTH-1:0] word_out
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word_valid <= 1'b0;
      word_out <= '0;
    end else if (load) begin
      word_valid <= 1'b1;
      word_out <= din;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
endmodule

// File: rtl/sipo_packer.sv
// sipo_packer: shifts in one bit per accepted cycle and hands each WIDTH-bit word to the holding register.
module sipo_packer import sipo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  sipo_i.dut s
);
  localparam int LAST = last_idx(WIDTH);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic last;
  logic acc;
  assign last = cnt == CW'(LAST);
  // ready looks only at registered state, so the completing bit waits for a fully drained holder
  assign s.bit_ready = !(last && s.word_valid);
  assign acc = s.bit_valid && s.bit_ready;
  assign word = MSB_FIRST ? {sr[WIDTH-2:0], s.bit_in} : {s.bit_in, sr[WIDTH-1:1]};
  always_ff @(posedge s.clk or negedge s.rst)
    if (!s.rst) begin
      cnt <= '0;
      sr <= '0;
    end else if (acc) begin
      cnt <= last ? '0 : cnt + 1'b1;
      sr <= last ? '0 : word;
    end
  sipo_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk(s.clk),
    .rst(s.rst),
    .load(acc && last),
    .din(word),
    .word_ready(s.word_ready),
    .word_valid(s.word_valid),
    .word_out(s.word_out)
  );
endmodule

// File: tb/tb_sipo_packer.sv
// tb_sipo_packer: scoreboard bench running MSB-first and LSB-first packers on one bit stream.
module tb_sipo_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sipo_i #(.WIDTH(8)) m (.clk(clk), .rst(rst_n));
  sipo_i #(.WIDTH(8)) l (.clk(clk), .rst(rst_n));
  sipo_packer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.s(m));
  sipo_packer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.s(l));
  // the LSB packer sees exactly the bits the MSB packer accepts
  assign l.bit_valid = m.bit_valid & m.bit_ready;
  assign l.bit_in = m.bit_in;
  int errors = 0;
  int checks = 0;
  logic [7:0] qm[$];
  logic [7:0] ql[$];
  logic [7:0] msr, lsr, held, last_m, last_l;
  int mcnt;
  bit mfull, lfull, hold_chk, acc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clear_model();
    mcnt = 0; msr = '0; lsr = '0; mfull = 0; lfull = 0; hold_chk = 0;
    qm.delete(); ql.delete();
  endtask
  task automatic cyc();
    logic [7:0] nm, nl;
    @(negedge clk);
    acc = m.bit_valid && m.bit_ready;
    chk("bit_ready", {31'd0, m.bit_ready}, {31'd0, !(mcnt == 7 && mfull)});
    chk("lsb_ready", {31'd0, l.bit_ready}, 32'd1);
    chk("word_valid", {31'd0, m.word_valid}, {31'd0, mfull});
    chk("lsb_valid", {31'd0, l.word_valid}, {31'd0, lfull});
    if (hold_chk && m.word_valid) chk("hold", {24'd0, m.word_out}, {24'd0, held});
    hold_chk = m.word_valid && !m.word_ready;
    held = m.word_out;
    if (m.word_valid && m.word_ready) begin
      last_m = m.word_out;
      if (qm.size() == 0) chk("msb_extra", {24'd0, m.word_out}, 32'hFFFF_FFFF);
      else chk("msb_word", {24'd0, m.word_out}, {24'd0, qm.pop_front()});
      mfull = 0;
    end
    if (l.word_valid && l.word_ready) begin
      last_l = l.word_out;
      if (ql.size() == 0) chk("lsb_extra", {24'd0, l.word_out}, 32'hFFFF_FFFF);
      else chk("lsb_word", {24'd0, l.word_out}, {24'd0, ql.pop_front()});
      lfull = 0;
    end
    if (acc) begin
      nm = {msr[6:0], m.bit_in};
      nl = {m.bit_in, lsr[7:1]};
      if (mcnt == 7) begin
        qm.push_back(nm); ql.push_back(nl);
        mfull = 1; lfull = 1; mcnt = 0; msr = '0; lsr = '0;
      end else begin
        mcnt++; msr = nm; lsr = nl;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b);
    m.bit_in = b;
    m.bit_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (acc) break;
    end
    chk("send_acc", {31'd0, acc}, 32'd1);
    m.bit_valid = 1'b0;
  endtask
  task automatic send_word(input logic [7:0] w, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      send(w[i]);
      if (gap) cyc();
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  initial begin
    logic [7:0] w;
    m.bit_in = 1'b0; m.bit_valid = 1'b0; m.word_ready = 1'b1; l.word_ready = 1'b1;
    clear_model();
    last_m = '0; last_l = '0; held = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, m.word_valid}, 32'd0);
    chk("rst_word", {24'd0, m.word_out}, 32'd0);
    chk("rst_ready", {31'd0, m.bit_ready}, 32'd1);
    rst_n = 1'b1;
    send_word(8'hB2, 0);
    idle(3);
    chk("msb_B2", {24'd0, last_m}, 32'hB2);
    chk("lsb_4D", {24'd0, last_l}, 32'h4D);
    m.word_ready = 1'b0;
    send_word(8'hFF, 0);
    w = 8'h81;
    for (int i = 7; i >= 1; i--) send(w[i]);
    chk("bp_valid", {31'd0, m.word_valid}, 32'd1);
    chk("bp_word", {24'd0, m.word_out}, 32'hFF);
    chk("bp_ready0", {31'd0, m.bit_ready}, 32'd0);
    m.bit_in = w[0]; m.bit_valid = 1'b1; m.word_ready = 1'b1;
    cyc();
    chk("bp_noacc", {31'd0, acc}, 32'd0);
    chk("bp_pop_FF", {24'd0, last_m}, 32'hFF);
    m.word_ready = 1'b0;
    cyc();
    chk("bp_acc", {31'd0, acc}, 32'd1);
    m.bit_valid = 1'b0; m.word_ready = 1'b1;
    idle(3);
    chk("bp_81", {24'd0, last_m}, 32'h81);
    send_word(8'hA5, 1);
    idle(3);
    chk("gap_A5", {24'd0, last_m}, 32'hA5);
    chk("gap_lsb", {24'd0, last_l}, 32'hA5);
    w = 8'h3C;
    for (int i = 7; i >= 3; i--) send(w[i]);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, m.word_valid}, 32'd0);
    chk("arst_word", {24'd0, m.word_out}, 32'd0);
    chk("arst_ready", {31'd0, m.bit_ready}, 32'd1);
    clear_model();
    rst_n = 1'b1;
    send_word(8'h3C, 0);
    idle(3);
    chk("arst_3C", {24'd0, last_m}, 32'h3C);
    for (int i = 0; i < 120; i++) begin
      m.word_ready = 1'($urandom_range(0, 1));
      m.bit_valid = 1'($urandom_range(0, 1));
      m.bit_in = 1'($urandom_range(0, 1));
      cyc();
    end
    m.bit_valid = 1'b0; m.word_ready = 1'b1;
    idle(4);
    chk("drain_msb", qm.size(), 32'd0);
    chk("drain_lsb", ql.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
